// File: rtl/nand_scrambler_pkg.sv
// nand_scrambler_pkg
// Shared definitions for the NAND page scrambler/descrambler pair:
//   - keystream LFSR width and feedback taps {0,4,5,6,8}
//   - seed-load feedback taps {0,4,5,6}
//   - replacement for an all-zero effective seed
//   - IDLE/RUN state encoding
//   - helper functions for LFSR load, LFSR shift and effective-seed calculation
package nand_scrambler_pkg;

    localparam int LFSR_W = 9;

    // Bit i set means state bit i feeds the XOR feedback.
    localparam logic [LFSR_W-1:0] LFSR_TAP_MASK = 9'b1_0111_0001;
    localparam logic [7:0]        SEED_TAP_MASK = 8'b0111_0001;

    // An all-zero LFSR state never leaves zero, so seed 0 is never loaded.
    localparam logic [7:0] ZERO_SEED_SUB = 8'h01;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } scramblerState_t;

    function automatic logic [LFSR_W-1:0] lfsrLoad(input logic [7:0] seed);
        return {seed, ^(seed & SEED_TAP_MASK)};
    endfunction

    function automatic logic [LFSR_W-1:0] lfsrShift(input logic [LFSR_W-1:0] s);
        return {s[7:0], ^(s & LFSR_TAP_MASK)};
    endfunction

    function automatic logic [7:0] effectiveSeed(input logic [7:0] base, input logic [7:0] idx);
        logic [7:0] sum;
        sum = base + idx;
        return (sum == 8'h00) ? ZERO_SEED_SUB : sum;
    endfunction

endpackage

// File: rtl/nand_data_descrambler_if.sv
// nand_data_descrambler_if
// Byte stream bundle around the descrambler: scrambled source stream in,
// descrambled destination stream out, valid/ready on both sides.
//   iSrcData/iSrcValid/oSrcReady : NAND read-data side
//   oDstData/oDstValid/iDstReady : ECC decoder side
// Modports: slave = descrambler view, master = surrounding logic / testbench.
interface nand_data_descrambler_if;

    logic [7:0] iSrcData;
    logic       iSrcValid;
    logic       oSrcReady;
    logic [7:0] oDstData;
    logic       oDstValid;
    logic       iDstReady;

    modport slave (
        input  iSrcData, iSrcValid, iDstReady,
        output oSrcReady, oDstData, oDstValid
    );

    modport master (
        output iSrcData, iSrcValid, iDstReady,
        input  oSrcReady, oDstData, oDstValid
    );

endinterface

// File: rtl/scrambler_keygen.sv
// scrambler_keygen
// Keystream generator shared by the scrambler and descrambler datapaths.
// Holds the 9-bit LFSR state; load has priority over shift.
//   iClock : rising-edge clock
//   iReset : asynchronous active-low reset (state clears to zero)
//   iLoad  : load the state from iSeed
//   iShift : advance the state by one step
//   iSeed  : effective seed (already zero-substituted by the caller)
//   oKey   : current keystream byte, S[7:0]
module scrambler_keygen
    import nand_scrambler_pkg::*;
(
    input  logic       iClock,
    input  logic       iReset,
    input  logic       iLoad,
    input  logic       iShift,
    input  logic [7:0] iSeed,
    output logic [7:0] oKey
);

    logic [LFSR_W-1:0] stateReg;

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            stateReg <= '0;
        end else if (iLoad) begin
            stateReg <= lfsrLoad(iSeed);
        end else if (iShift) begin
            stateReg <= lfsrShift(stateReg);
        end
    end

    assign oKey = stateReg[7:0];

endmodule

// File: rtl/nand_data_descrambler.sv
// nand_data_descrambler
// Read-path descrambler: XORs the LFSR keystream off NAND page bytes, one
// byte per beat, with a single output register between source and sink.
// Optional feature macro: DESCRAMBLER_CHUNK_RESEED_EN
//   defined   : LFSR reloads at every chunk boundary with (base + chunk) mod 256
//   undefined : LFSR loads only on iSeedValid and runs across the whole page
// Ports:
//   iClock, iReset   : clock, asynchronous active-low reset
//   iSeed/iSeedValid : page base seed and one-cycle page start
//   bus              : source/destination byte streams (slave modport)
//   oChunkDone       : one-cycle pulse alongside the last byte of each chunk
//   oBusy            : running, or output register still holds a byte
module nand_data_descrambler
    import nand_scrambler_pkg::*;
#(
    parameter int CHUNK_BYTES = 512,
    parameter int CNT_W       = 12
) (
    input  logic                    iClock,
    input  logic                    iReset,
    input  logic [7:0]              iSeed,
    input  logic                    iSeedValid,
    nand_data_descrambler_if.slave  bus,
    output logic                    oChunkDone,
    output logic                    oBusy
);

    scramblerState_t stateReg, stateNext;

    logic [CNT_W-1:0] cntReg;
    logic [7:0]       dstDataReg;
    logic             dstValidReg;
    logic             chunkDoneReg;

    logic       srcReady;
    logic       accept;
    logic       lastByte;
    logic       keyLoad;
    logic       keyShift;
    logic [7:0] keySeed;
    logic [7:0] key;

    // State register
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next state and source-side handshake. A page start blocks the source
    // for that cycle so the new seed always wins over a same-cycle byte.
    always_comb begin
        stateNext = stateReg;
        srcReady  = 1'b0;
        if (iSeedValid) begin
            stateNext = RUN;
        end
        if (stateReg == RUN && !iSeedValid && (!dstValidReg || bus.iDstReady)) begin
            srcReady = 1'b1;
        end
    end

    assign accept   = bus.iSrcValid && srcReady;
    assign lastByte = (cntReg == CNT_W'(CHUNK_BYTES - 1));

    // In-chunk byte counter; wraps at the chunk size in both build variants.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            cntReg <= '0;
        end else if (iSeedValid) begin
            cntReg <= '0;
        end else if (accept) begin
            cntReg <= lastByte ? '0 : cntReg + 1'b1;
        end
    end

`ifdef DESCRAMBLER_CHUNK_RESEED_EN
    logic [7:0] baseReg;
    logic [7:0] idxReg;

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            baseReg <= 8'h00;
            idxReg  <= 8'h00;
        end else if (iSeedValid) begin
            baseReg <= iSeed;
            idxReg  <= 8'h00;
        end else if (accept && lastByte) begin
            idxReg  <= idxReg + 8'h01;
        end
    end

    // At a chunk boundary the next chunk's seed replaces the shift.
    assign keyLoad = iSeedValid || (accept && lastByte);
    assign keySeed = iSeedValid ? effectiveSeed(iSeed, 8'h00)
                                : effectiveSeed(baseReg, idxReg + 8'h01);
`else
    assign keyLoad = iSeedValid;
    assign keySeed = effectiveSeed(iSeed, 8'h00);
`endif

    assign keyShift = accept && !keyLoad;

    scrambler_keygen u_keygen (
        .iClock (iClock),
        .iReset (iReset),
        .iLoad  (keyLoad),
        .iShift (keyShift),
        .iSeed  (keySeed),
        .oKey   (key)
    );

    // Output register: loads on accept, empties when the sink takes the byte,
    // data held untouched otherwise.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            dstDataReg   <= 8'h00;
            dstValidReg  <= 1'b0;
            chunkDoneReg <= 1'b0;
        end else begin
            chunkDoneReg <= accept && lastByte;
            if (accept) begin
                dstDataReg  <= bus.iSrcData ^ key;
                dstValidReg <= 1'b1;
            end else if (bus.iDstReady) begin
                dstValidReg <= 1'b0;
            end
        end
    end

    assign bus.oSrcReady = srcReady;
    assign bus.oDstData  = dstDataReg;
    assign bus.oDstValid = dstValidReg;
    assign oChunkDone    = chunkDoneReg;
    assign oBusy         = (stateReg == RUN) || dstValidReg;

endmodule

// File: tb/tb_nand_data_descrambler.sv
// Directed testbench for nand_data_descrambler (CHUNK_BYTES=4).
// Expected chunk-test bytes follow DESCRAMBLER_CHUNK_RESEED_EN if defined.
module tb_nand_data_descrambler;

    logic       iClock = 1'b0;
    logic       iReset = 1'b1;
    logic [7:0] iSeed;
    logic       iSeedValid;
    logic       oChunkDone;
    logic       oBusy;

    int total = 0;
    int bad   = 0;

    nand_data_descrambler_if bus ();

    nand_data_descrambler #(
        .CHUNK_BYTES (4),
        .CNT_W       (12)
    ) dut (
        .iClock     (iClock),
        .iReset     (iReset),
        .iSeed      (iSeed),
        .iSeedValid (iSeedValid),
        .bus        (bus),
        .oChunkDone (oChunkDone),
        .oBusy      (oBusy)
    );

    always #5 iClock = ~iClock;

    // Reference keystream model, written straight from the bit equations.
    function automatic logic [8:0] mLoad(input logic [7:0] s);
        logic [7:0] e;
        e = (s == 8'h00) ? 8'h01 : s;
        return {e, e[0] ^ e[4] ^ e[5] ^ e[6]};
    endfunction

    function automatic logic [8:0] mShift(input logic [8:0] s);
        return {s[7:0], s[0] ^ s[4] ^ s[5] ^ s[6] ^ s[8]};
    endfunction

    task automatic step;
        @(posedge iClock);
        #1;
    endtask

    task automatic idleInputs;
        iSeed          = 8'h00;
        iSeedValid     = 1'b0;
        bus.iSrcData   = 8'h00;
        bus.iSrcValid  = 1'b0;
        bus.iDstReady  = 1'b1;
    endtask

    task automatic doReset;
        idleInputs();
        iReset = 1'b0;
        step();
        iReset = 1'b1;
        step();
    endtask

    task automatic loadSeed(input logic [7:0] s);
        iSeed      = s;
        iSeedValid = 1'b1;
        step();
        iSeedValid = 1'b0;
    endtask

    task automatic test_reset;
        idleInputs();
        #1;
        iReset = 1'b0;
        #2;
        total++; if (bus.oDstValid !== 1'b0) begin bad++; $display("FAIL reset_dst_valid: got %b want 0", bus.oDstValid); end
        total++; if (bus.oDstData !== 8'h00) begin bad++; $display("FAIL reset_dst_data: got %h want 00", bus.oDstData); end
        total++; if (bus.oSrcReady !== 1'b0) begin bad++; $display("FAIL reset_src_ready: got %b want 0", bus.oSrcReady); end
        total++; if (oChunkDone !== 1'b0) begin bad++; $display("FAIL reset_chunk_done: got %b want 0", oChunkDone); end
        total++; if (oBusy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", oBusy); end
        step();
        iReset = 1'b1;
        bus.iSrcValid = 1'b1;
        step();
        total++; if (bus.oSrcReady !== 1'b0) begin bad++; $display("FAIL idle_src_ready: got %b want 0", bus.oSrcReady); end
        total++; if (bus.oDstValid !== 1'b0) begin bad++; $display("FAIL idle_dst_valid: got %b want 0", bus.oDstValid); end
        bus.iSrcValid = 1'b0;
        $display("reset: checks done");
    endtask

    task automatic test_basic;
        logic [7:0] want[3];
        want = '{8'h03, 8'h07, 8'h0F};
        doReset();
        loadSeed(8'h01);
        total++; if (oBusy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", oBusy); end
        bus.iSrcValid = 1'b1;
        bus.iSrcData  = 8'h00;
        #1;
        total++; if (bus.oSrcReady !== 1'b1) begin bad++; $display("FAIL basic_src_ready: got %b want 1", bus.oSrcReady); end
        total++; if (bus.oDstValid !== 1'b0) begin bad++; $display("FAIL basic_early_valid: got %b want 0", bus.oDstValid); end
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 2) bus.iSrcValid = 1'b0;
            $display("basic byte %0d: out=%h", i, bus.oDstData);
            total++; if (bus.oDstValid !== 1'b1) begin bad++; $display("FAIL basic_valid_%0d: got %b want 1", i, bus.oDstValid); end
            total++; if (bus.oDstData !== want[i]) begin bad++; $display("FAIL basic_data_%0d: got %h want %h", i, bus.oDstData, want[i]); end
        end
        step();
        total++; if (bus.oDstValid !== 1'b0) begin bad++; $display("FAIL basic_drain: got %b want 0", bus.oDstValid); end
    endtask

    task automatic test_round_trip;
        doReset();
        loadSeed(8'hFF);
        bus.iSrcValid = 1'b1;
        bus.iSrcData  = 8'h00;
        step();
        bus.iSrcValid = 1'b0;
        $display("round trip scramble: out=%h", bus.oDstData);
        total++; if (bus.oDstData !== 8'hFE) begin bad++; $display("FAIL rt_scramble: got %h want fe", bus.oDstData); end
        loadSeed(8'hFF);
        bus.iSrcValid = 1'b1;
        bus.iSrcData  = 8'hFE;
        step();
        bus.iSrcValid = 1'b0;
        $display("round trip restore: out=%h", bus.oDstData);
        total++; if (bus.oDstValid !== 1'b1) begin bad++; $display("FAIL rt_valid: got %b want 1", bus.oDstValid); end
        total++; if (bus.oDstData !== 8'h00) begin bad++; $display("FAIL rt_restore: got %h want 00", bus.oDstData); end
    endtask

    task automatic test_chunk;
        logic [7:0] want[8];
        logic       wantDone;
`ifdef DESCRAMBLER_CHUNK_RESEED_EN
        want = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'h03, 8'h07, 8'h0F, 8'h1F};
`else
        want = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC1, 8'h83, 8'h06};
`endif
        doReset();
        loadSeed(8'hFF);
        bus.iSrcValid = 1'b1;
        bus.iSrcData  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 7) bus.iSrcValid = 1'b0;
            wantDone = ((i % 4) == 3);
            $display("chunk byte %0d: out=%h done=%b", i, bus.oDstData, oChunkDone);
            total++; if (bus.oDstData !== want[i]) begin bad++; $display("FAIL chunk_data_%0d: got %h want %h", i, bus.oDstData, want[i]); end
            total++; if (oChunkDone !== wantDone) begin bad++; $display("FAIL chunk_done_%0d: got %b want %b", i, oChunkDone, wantDone); end
        end
        step();
        total++; if (oChunkDone !== 1'b0) begin bad++; $display("FAIL chunk_done_after: got %b want 0", oChunkDone); end
    endtask

    task automatic test_backpressure;
        logic [7:0] dIn[64];
        logic [7:0] expd[64];
        logic [8:0] s;
        logic [7:0] chunk;
        logic [7:0] preData;
        logic       preAcc, prePop, preStall;
        int         sent, recv;
        s = mLoad(8'hA5);
        chunk = 8'h00;
        for (int i = 0; i < 64; i++) begin
            dIn[i]  = 8'(i * 37 + 5);
            expd[i] = dIn[i] ^ s[7:0];
`ifdef DESCRAMBLER_CHUNK_RESEED_EN
            if ((i % 4) == 3) begin
                chunk = chunk + 8'h01;
                s = mLoad(8'hA5 + chunk);
            end else begin
                s = mShift(s);
            end
`else
            s = mShift(s);
`endif
        end
        doReset();
        loadSeed(8'hA5);
        sent = 0;
        recv = 0;
        bus.iSrcValid = 1'b1;
        bus.iSrcData  = dIn[0];
        bus.iDstReady = ($urandom_range(0, 2) != 0);
        for (int cyc = 0; cyc < 1000 && recv < 64; cyc++) begin
            @(negedge iClock);
            preAcc   = bus.iSrcValid && bus.oSrcReady;
            prePop   = bus.oDstValid && bus.iDstReady;
            preStall = bus.oDstValid && !bus.iDstReady;
            preData  = bus.oDstData;
            if (prePop) begin
                $display("stream byte %0d: out=%h want=%h", recv, preData, expd[recv]);
                total++; if (preData !== expd[recv]) begin bad++; $display("FAIL stream_data_%0d: got %h want %h", recv, preData, expd[recv]); end
                recv++;
            end
            @(posedge iClock);
            #1;
            if (preStall) begin
                total++;
                if (bus.oDstValid !== 1'b1 || bus.oDstData !== preData) begin
                    bad++;
                    $display("FAIL stall_hold: got valid=%b data=%h want valid=1 data=%h", bus.oDstValid, bus.oDstData, preData);
                end
            end
            if (preAcc) sent++;
            bus.iSrcValid = (sent < 64);
            if (sent < 64) bus.iSrcData = dIn[sent];
            bus.iDstReady = ($urandom_range(0, 2) != 0);
        end
        total++; if (recv != 64) begin bad++; $display("FAIL stream_count: got %0d want 64", recv); end
        bus.iSrcValid = 1'b0;
        bus.iDstReady = 1'b1;
        step();
        step();
        total++; if (bus.oDstValid !== 1'b0) begin bad++; $display("FAIL stream_extra: got valid %b want 0", bus.oDstValid); end
    endtask

    task automatic test_seed_priority;
        doReset();
        loadSeed(8'h01);
        bus.iSrcValid = 1'b1;
        bus.iSrcData  = 8'h00;
        step();
        total++; if (bus.oDstData !== 8'h03) begin bad++; $display("FAIL prio_first: got %h want 03", bus.oDstData); end
        iSeed      = 8'h01;
        iSeedValid = 1'b1;
        #1;
        total++; if (bus.oSrcReady !== 1'b0) begin bad++; $display("FAIL prio_ready: got %b want 0", bus.oSrcReady); end
        step();
        iSeedValid = 1'b0;
        total++; if (bus.oDstValid !== 1'b0) begin bad++; $display("FAIL prio_no_accept: got %b want 0", bus.oDstValid); end
        step();
        bus.iSrcValid = 1'b0;
        $display("seed priority: out=%h", bus.oDstData);
        total++; if (bus.oDstValid !== 1'b1 || bus.oDstData !== 8'h03) begin bad++; $display("FAIL prio_restart: got valid=%b data=%h want valid=1 data=03", bus.oDstValid, bus.oDstData); end
    endtask

    task automatic test_reset_mid;
        doReset();
        loadSeed(8'h01);
        bus.iSrcValid = 1'b1;
        bus.iSrcData  = 8'h00;
        bus.iDstReady = 1'b0;
        step();
        total++; if (bus.oDstValid !== 1'b1) begin bad++; $display("FAIL mid_valid_before: got %b want 1", bus.oDstValid); end
        #2;
        iReset = 1'b0;
        #1;
        total++; if (bus.oDstValid !== 1'b0) begin bad++; $display("FAIL mid_valid_async: got %b want 0", bus.oDstValid); end
        total++; if (bus.oSrcReady !== 1'b0) begin bad++; $display("FAIL mid_ready_async: got %b want 0", bus.oSrcReady); end
        total++; if (oBusy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", oBusy); end
        step();
        iReset = 1'b1;
        bus.iDstReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (bus.oSrcReady !== 1'b0 || bus.oDstValid !== 1'b0) begin bad++; $display("FAIL mid_wait_%0d: got ready=%b valid=%b want 0/0", i, bus.oSrcReady, bus.oDstValid); end
        end
        loadSeed(8'h01);
        #1;
        total++; if (bus.oSrcReady !== 1'b1) begin bad++; $display("FAIL mid_reseed_ready: got %b want 1", bus.oSrcReady); end
        step();
        bus.iSrcValid = 1'b0;
        $display("reset mid-page: out after reseed=%h", bus.oDstData);
        total++; if (bus.oDstData !== 8'h03) begin bad++; $display("FAIL mid_reseed_data: got %h want 03", bus.oDstData); end
    endtask

    initial begin
        idleInputs();
        test_reset();
        test_basic();
        test_round_trip();
        test_chunk();
        test_backpressure();
        test_seed_priority();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nand_data_descrambler.md
# nand_data_descrambler

Read-path descrambler for NAND page data: removes the LFSR keystream that the write path XORs onto page bytes before programming. Sits between the NAND read-data stream and the ECC decoder, one byte per beat, valid/ready on both sides, reseeded per page and, optionally, per chunk.

## Interface
- CHUNK_BYTES, 512: bytes per keystream chunk; power of two, 4..4096.
- CNT_W, 12: width of the in-chunk byte counter; must satisfy 2^CNT_W ≥ CHUNK_BYTES.
- iClock  in  1  rising-edge clock.
- iReset  in  1  asynchronous, active-low reset.
- iSeed  in  8  page base seed, sampled when iSeedValid is high.
- iSeedValid  in  1  one-cycle page start: latch the base seed, zero the chunk index, load the LFSR.
- iSrcData  in  8  scrambled byte from NAND.
- iSrcValid  in  1  iSrcData is valid.
- oSrcReady  out  1  byte accepted when iSrcValid && oSrcReady.
- oDstData  out  8  descrambled byte.
- oDstValid  out  1  oDstData is valid.
- iDstReady  in  1  downstream accepts the byte.
- oChunkDone  out  1  one-cycle pulse after the last byte of a chunk is accepted.
- oBusy  out  1  seeded and able to accept data, or output register occupied.

## Operation
- Keystream generator: 9-bit state S.
  - Load with seed s: S = {s[7:0], s[0]^s[4]^s[5]^s[6]}.
  - Shift: S = {S[7:0], S[0]^S[4]^S[5]^S[6]^S[8]}.
  - Keystream byte is S[7:0].
- Effective seed for chunk k is (base + k) mod 256. An effective seed of 8'h00 is replaced by 8'h01, because an all-zero state would lock up.
- On each accepted byte:
  - Output byte = iSrcData ^ S[7:0].
  - S shifts.
  - The byte counter increments.
- When the counter reaches CHUNK_BYTES-1 and a byte is accepted:
  - The counter wraps to 0.
  - The chunk index increments (8-bit, wraps 255→0).
  - S reloads with the next effective seed instead of shifting.
  - oChunkDone pulses on the next cycle.
- States:
  - IDLE (after reset): oSrcReady=0.
  - RUN (entered on iSeedValid; no exit except reset).
  - iSeedValid in RUN restarts the page: base re-latched, counter and index zeroed, S reloaded.
- Priority: iSeedValid beats a same-cycle source byte. oSrcReady is forced 0 while iSeedValid is high. The output register keeps its byte and drains normally.
- Pipeline: a single output register. oSrcReady = RUN && !iSeedValid && (!oDstValid || iDstReady).
- Backpressure: with iDstReady low, oDstData/oDstValid stay stable, and S and the counters do not advance.

## Timing
- Latency 1: a byte accepted at edge n is presented on oDstData/oDstValid after edge n.
- Throughput: 1 byte/cycle when iDstReady is held high.
- Reset values: oDstValid=0, oDstData=8'h00, oSrcReady=0, oChunkDone=0, oBusy=0; S=0, counter=0, index=0, state IDLE.
- Reset asserted mid-page: all state clears asynchronously. The in-flight byte is discarded. A new iSeedValid is required.
- oChunkDone is registered and high for exactly one cycle, aligned with oDstValid of the chunk's last byte.

## Configuration
- DESCRAMBLER_CHUNK_RESEED_EN defined: per-chunk reseed as described above.
- Not defined:
  - S is loaded only on iSeedValid and shifts for every accepted byte across the whole page.
  - The chunk index is removed.
  - The counter still wraps at CHUNK_BYTES and still drives oChunkDone.

## Structure
- Shared package nand_scrambler_pkg holds:
  - LFSR width (9) and tap positions {0,4,5,6,8}.
  - Seed tap positions {0,4,5,6}.
  - Zero-seed replacement constant 8'h01.
  - State encoding IDLE/RUN.
- The write-path scrambler uses the same package.
- Sub-module scrambler_keygen: holds S and has load, shift, seed and key outputs. The descrambler instantiates it; the write path reuses it.

## Test plan
- Seed 8'h01, three 8'h00 bytes, iDstReady=1 → outputs 8'h03, 8'h07, 8'h0F at one byte/cycle, each one cycle after acceptance.
- Seed 8'hFF, byte 8'h00 → 8'hFE. Byte 8'hFE with the same seed → 8'h00 (round trip).
- CHUNK_BYTES=4, reseed enabled, seed 8'hFF, eight 8'h00 bytes:
  - byte 0 → 8'hFE.
  - byte 4 → 8'h03 (index wraps to seed 0, replaced by 8'h01).
  - oChunkDone pulses with bytes 3 and 7.
- Same stimulus with the macro undefined:
  - byte 4 continues the unbroken 8'hFF sequence.
  - oChunkDone still pulses with bytes 3 and 7.
- Random iDstReady stalls over 64 bytes:
  - oDstData is stable while stalled.
  - Output equals the model stream with no drops or duplicates.
- iSeedValid=8'h01 asserted with iSrcValid high mid-chunk → the byte is not accepted that cycle. The next accepted 8'h00 yields 8'h03.
- iReset pulsed low with oDstValid=1 → oDstValid=0 immediately, oSrcReady=0 until the next iSeedValid.
